// File: rtl/mha_pe_pkg.sv
// Shared types and fixed-point helpers for the MHA systolic processing element.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// The helpers work on a 64-bit signed carrier so that one function serves every
// DW/FW combination. Callers sign-extend into wide_t and size-cast the result back.
// This requires 2*DW+2 <= 64 and FW >= 1.
package mha_pe_pkg;

    localparam int DEFAULT_DW = 16;
    localparam int DEFAULT_FW = 13;
    localparam int WIDE_W     = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic {
        PE_MODE_PASS = 1'b0,
        PE_MODE_ACC  = 1'b1
    } pe_mode_e;

    typedef enum logic [1:0] {
        PE_IDLE = 2'd0,
        PE_ACC  = 2'd1,
        PE_DUMP = 2'd2
    } pe_state_e;

    // Round to nearest, with ties toward +inf: add half an LSB, then shift
    // arithmetically.
    function automatic wide_t round_shift(input wide_t p, input int fw);
        wide_t half;
        half = wide_t'(1) <<< (fw - 1);
        return (p + half) >>> fw;
    endfunction

    // Clamp v to the signed range of a dw-bit two's-complement value.
    function automatic wide_t sat_to_dw(input wide_t v, input int dw);
        wide_t hi;
        wide_t lo;
        wide_t res;
        hi  = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (dw - 1));
        res = v;
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// Signed DW x DW multiplier, MUL_STAGES register stages, with D/mode/last tags aligned to the product.
// Latency: MUL_STAGES cycles from I_VLD to O_VLD.
// Backpressure: none; accepts one operation per cycle unconditionally.
//
// Ports: I_CLK/I_RST_N clock and async active-low reset; I_VLD/I_X/I_W/I_D/I_MODE/I_LAST
// form the issued operation; O_VLD/O_PROD/O_D/O_MODE/O_LAST are the same operation after
// the pipeline; O_BUSY is high while any stage holds a valid operation.
// The product is formed at the head of the chain. Later stages only delay it, so
// synthesis retiming can spread the multiplier across them. MUL_STAGES must be >= 1.
module pe_mul_pipe
    import mha_pe_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int MUL_STAGES = 2
) (
    input  logic                   I_CLK,
    input  logic                   I_RST_N,
    input  logic                   I_VLD,
    input  logic [DW-1:0]          I_X,
    input  logic [DW-1:0]          I_W,
    input  logic [DW-1:0]          I_D,
    input  logic                   I_MODE,
    input  logic                   I_LAST,
    output logic                   O_VLD,
    output logic signed [2*DW-1:0] O_PROD,
    output logic [DW-1:0]          O_D,
    output logic                   O_MODE,
    output logic                   O_LAST,
    output logic                   O_BUSY
);

    localparam int PW = 2 * DW;

    logic [MUL_STAGES-1:0]  vld_q;
    logic signed [PW-1:0]   prod_q [MUL_STAGES];
    logic [DW-1:0]          d_q    [MUL_STAGES];
    pe_mode_e               mode_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]  last_q;

    logic signed [PW-1:0]   prod_in;

    // The full-width product of two DW-bit signed values always fits in 2*DW bits.
    assign prod_in = PW'($signed(I_X)) * PW'($signed(I_W));

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
                d_q[i]    <= '0;
                mode_q[i] <= PE_MODE_PASS;
            end
        end else begin
            vld_q[0] <= I_VLD;
            // The data registers only load when a valid operation arrives.
            // Valid gates every use of them downstream.
            if (I_VLD) begin
                prod_q[0] <= prod_in;
                d_q[0]    <= I_D;
                mode_q[0] <= pe_mode_e'(I_MODE);
                last_q[0] <= I_LAST;
            end
            for (int i = 1; i < MUL_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    prod_q[i] <= prod_q[i-1];
                    d_q[i]    <= d_q[i-1];
                    mode_q[i] <= mode_q[i-1];
                    last_q[i] <= last_q[i-1];
                end
            end
        end
    end

    assign O_VLD  = vld_q[MUL_STAGES-1];
    assign O_PROD = prod_q[MUL_STAGES-1];
    assign O_D    = d_q[MUL_STAGES-1];
    assign O_MODE = mode_q[MUL_STAGES-1];
    assign O_LAST = last_q[MUL_STAGES-1];
    assign O_BUSY = |vld_q;

endmodule

// File: rtl/pe_mac_param.sv
// Systolic PE: O_OUT = sat(round(X*W) + D) pass-down, or a local accumulate-and-dump mode.
// Latency: MUL_STAGES+1 cycles from I_X_VLD to O_OUT_VLD; X forwarded after 1 cycle.
// Backpressure: none; one operation per cycle sustained, and results are single-cycle pulses.
//
// Ports: I_CLK/I_RST_N clock and async active-low reset; I_MODE 0=pass-down, 1=accumulate;
// I_W_LOAD/I_W load the stationary weight; I_X_VLD/I_X issue an op; I_D_VLD/I_D partial sum
// from above (treated as 0 when I_D_VLD=0); I_LAST ends an accumulation; O_X_VLD/O_X go to the
// right neighbour; O_OUT_VLD/O_OUT are the result; O_BUSY means ops in flight or accumulator in use.
// Build macro PE_SAT_EN: when defined, results saturate to DW bits. Otherwise they wrap to the low DW bits.
module pe_mac_param
    import mha_pe_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int FW         = DEFAULT_FW,
    parameter int MUL_STAGES = 2,
    parameter int GUARD      = 4
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_MODE,
    input  logic          I_W_LOAD,
    input  logic [DW-1:0] I_W,
    input  logic          I_X_VLD,
    input  logic [DW-1:0] I_X,
    input  logic          I_D_VLD,
    input  logic [DW-1:0] I_D,
    input  logic          I_LAST,
    output logic          O_X_VLD,
    output logic [DW-1:0] O_X,
    output logic          O_OUT_VLD,
    output logic [DW-1:0] O_OUT,
    output logic          O_BUSY
);

    localparam int ACC_W = DW + GUARD;

    // ---------------- stationary weight ----------------
    // An op issued in the same cycle as a load sees the old value, because the
    // multiplier samples w_q before this edge updates it.
    logic [DW-1:0] w_q;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            w_q <= '0;
        end else if (I_W_LOAD) begin
            w_q <= I_W;
        end
    end

    // ---------------- X forwarding ----------------
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_X_VLD <= 1'b0;
            O_X     <= '0;
        end else begin
            O_X_VLD <= I_X_VLD;
            O_X     <= I_X_VLD ? I_X : '0;
        end
    end

    // ---------------- multiplier pipeline ----------------
    logic [DW-1:0]          d_issue;
    logic                   p_vld;
    logic signed [2*DW-1:0] p_prod;
    logic [DW-1:0]          p_d;
    logic                   p_mode;
    logic                   p_last;
    logic                   p_busy;

    // A missing partial sum (top row of the array) contributes zero.
    assign d_issue = I_D_VLD ? I_D : '0;

    pe_mul_pipe #(
        .DW         (DW),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_VLD   (I_X_VLD),
        .I_X     (I_X),
        .I_W     (w_q),
        .I_D     (d_issue),
        .I_MODE  (I_MODE),
        .I_LAST  (I_LAST),
        .O_VLD   (p_vld),
        .O_PROD  (p_prod),
        .O_D     (p_d),
        .O_MODE  (p_mode),
        .O_LAST  (p_last),
        .O_BUSY  (p_busy)
    );

    // ---------------- arithmetic ----------------
    pe_state_e            state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    wide_t r_w;
    wide_t d_w;
    wide_t acc_base;
    wide_t sum_pass;
    wide_t sum_acc;

    // All sums use the wide carrier, so neither a pass-down sum nor a dump ever
    // overflows before the final saturate or wrap.
    always_comb begin
        r_w      = round_shift(wide_t'(p_prod), FW);
        d_w      = wide_t'($signed(p_d));
        // The accumulator only holds live data in ACC. In IDLE and DUMP a new
        // product seeds a fresh sum.
        acc_base = (state_q == PE_ACC) ? wide_t'(acc_q) : '0;
        sum_pass = r_w + d_w;
        sum_acc  = acc_base + r_w;
    end

    // ---------------- mode-1 FSM and result select ----------------
    logic          res_vld_d;
    wide_t         res_w;
    logic [DW-1:0] res_d;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        res_vld_d = 1'b0;
        res_w     = '0;
        res_d     = '0;

        if (p_vld && (p_mode == PE_MODE_PASS)) begin
            res_vld_d = 1'b1;
            res_w     = sum_pass;
            if (state_q == PE_DUMP) begin
                state_d = PE_IDLE;
            end
        end else if (p_vld) begin
            if (p_last) begin
                res_vld_d = 1'b1;
                res_w     = sum_acc;
                acc_d     = '0;
                state_d   = PE_DUMP;
            end else begin
                // The guard bits absorb intermediate growth. Wrapping at ACC_W is
                // the accepted behaviour if they are exhausted.
                acc_d   = ACC_W'(sum_acc);
                state_d = PE_ACC;
            end
        end else if (state_q == PE_DUMP) begin
            state_d = PE_IDLE;
        end

        if (res_vld_d) begin
`ifdef PE_SAT_EN
            res_d = DW'(sat_to_dw(res_w, DW));
`else
            res_d = DW'(res_w);
`endif
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q   <= PE_IDLE;
            acc_q     <= '0;
            O_OUT_VLD <= 1'b0;
            O_OUT     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            O_OUT_VLD <= res_vld_d;
            O_OUT     <= res_d;
        end
    end

    assign O_BUSY = p_busy | (state_q == PE_ACC);

endmodule

// File: tb/tb_pe_mac_param.sv
// Directed bench for pe_mac_param (default parameters: DW=16, FW=13, MUL_STAGES=2, LAT=3).
// Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
module tb_pe_mac_param;

    logic        I_CLK;
    logic        I_RST_N;
    logic        I_MODE;
    logic        I_W_LOAD;
    logic [15:0] I_W;
    logic        I_X_VLD;
    logic [15:0] I_X;
    logic        I_D_VLD;
    logic [15:0] I_D;
    logic        I_LAST;
    logic        O_X_VLD;
    logic [15:0] O_X;
    logic        O_OUT_VLD;
    logic [15:0] O_OUT;
    logic        O_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PE_SAT_EN
    localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
    localparam logic [15:0] EXP_D_OVF   = 16'h7FFF;
    localparam logic [15:0] EXP_ACC_OVF = 16'h7FFF;
`else
    localparam logic [15:0] EXP_POS_OVF = 16'h2000;
    localparam logic [15:0] EXP_NEG_OVF = 16'hE000;
    localparam logic [15:0] EXP_D_OVF   = 16'hFFFE;
    localparam logic [15:0] EXP_ACC_OVF = 16'h4000;
`endif

    pe_mac_param dut (
        .I_CLK     (I_CLK),
        .I_RST_N   (I_RST_N),
        .I_MODE    (I_MODE),
        .I_W_LOAD  (I_W_LOAD),
        .I_W       (I_W),
        .I_X_VLD   (I_X_VLD),
        .I_X       (I_X),
        .I_D_VLD   (I_D_VLD),
        .I_D       (I_D),
        .I_LAST    (I_LAST),
        .O_X_VLD   (O_X_VLD),
        .O_X       (O_X),
        .O_OUT_VLD (O_OUT_VLD),
        .O_OUT     (O_OUT),
        .O_BUSY    (O_BUSY)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic load_w(input logic [15:0] w);
        I_W_LOAD = 1'b1;
        I_W      = w;
        step();
        I_W_LOAD = 1'b0;
    endtask

    // Issue one op across one edge. I_MODE is left held for the next op. The
    // protocol rule is that the mode may only change while the PE is idle.
    task automatic issue(input logic [15:0] x, input logic [15:0] d, input logic dvld,
                         input logic mode, input logic last);
        if (O_BUSY === 1'b1) check("mode_stable", {31'd0, mode}, {31'd0, I_MODE});
        I_MODE  = mode;
        I_X_VLD = 1'b1;
        I_X     = x;
        I_D_VLD = dvld;
        I_D     = d;
        I_LAST  = last;
        step();
        I_X_VLD  = 1'b0;
        I_X      = '0;
        I_D_VLD  = 1'b0;
        I_D      = '0;
        I_LAST   = 1'b0;
        I_W_LOAD = 1'b0;
    endtask

    // One isolated pass-down op. The result must appear exactly 3 edges after issue.
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] d,
                          input logic dvld, input logic [15:0] exp);
        issue(x, d, dvld, 1'b0, 1'b0);
        step();
        check({tag, "_early"}, {31'd0, O_OUT_VLD}, 32'd0);
        step();
        check({tag, "_vld"}, {31'd0, O_OUT_VLD}, 32'd1);
        check(tag, {16'd0, O_OUT}, {16'd0, exp});
        step();
        check({tag, "_pulse"}, {31'd0, O_OUT_VLD}, 32'd0);
        check({tag, "_zero"}, {16'd0, O_OUT}, 32'd0);
    endtask

    initial begin
        logic any_vld;
        I_RST_N  = 1'b0;
        I_MODE   = 1'b0;
        I_W_LOAD = 1'b0;
        I_W      = '0;
        I_X_VLD  = 1'b0;
        I_X      = '0;
        I_D_VLD  = 1'b0;
        I_D      = '0;
        I_LAST   = 1'b0;
        step();
        step();
        check("rst_x_vld", {31'd0, O_X_VLD}, 32'd0);
        check("rst_x", {16'd0, O_X}, 32'd0);
        check("rst_out_vld", {31'd0, O_OUT_VLD}, 32'd0);
        check("rst_out", {16'd0, O_OUT}, 32'd0);
        check("rst_busy", {31'd0, O_BUSY}, 32'd0);
        I_RST_N = 1'b1;
        step();

        // Reset asserted while an op is in flight discards it.
        load_w(16'h2000);
        issue(16'h2000, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("mid_busy_before", {31'd0, O_BUSY}, 32'd1);
        I_RST_N = 1'b0;
        #1;
        check("mid_busy_rst", {31'd0, O_BUSY}, 32'd0);
        check("mid_xvld_rst", {31'd0, O_X_VLD}, 32'd0);
        step();
        I_RST_N = 1'b1;
        any_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            any_vld = any_vld | O_OUT_VLD;
        end
        check("mid_no_vld", {31'd0, any_vld}, 32'd0);
        check("mid_out", {16'd0, O_OUT}, 32'd0);
        // The weight register was cleared as well, so the product is zero.
        run_op("w_cleared", 16'h2000, 16'h0000, 1'b0, 16'h0000);

        // Pass mode, including X forwarding timing.
        load_w(16'h2000);
        issue(16'h2000, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("fwd_x_vld", {31'd0, O_X_VLD}, 32'd1);
        check("fwd_x", {16'd0, O_X}, 32'h2000);
        check("pass_busy", {31'd0, O_BUSY}, 32'd1);
        step();
        check("fwd_x_vld_drop", {31'd0, O_X_VLD}, 32'd0);
        check("fwd_x_zero", {16'd0, O_X}, 32'd0);
        check("pass_early", {31'd0, O_OUT_VLD}, 32'd0);
        step();
        check("pass_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("pass_out", {16'd0, O_OUT}, 32'h2000);
        step();
        check("pass_pulse", {31'd0, O_OUT_VLD}, 32'd0);
        check("pass_idle", {31'd0, O_BUSY}, 32'd0);
        run_op("top_row_d_ignored", 16'h2000, 16'h1000, 1'b0, 16'h2000);

        // Negative operands: 2.0 * -1.0 + 0.5 = -1.5
        load_w(16'h4000);
        run_op("neg", 16'hE000, 16'h1000, 1'b1, 16'hD000);

        // Rounding with W = 1 LSB: X*W/2^13 is close to a half LSB.
        load_w(16'h0001);
        run_op("rnd_half_up", 16'h1000, 16'h0000, 1'b1, 16'h0001);
        run_op("rnd_below", 16'h0FFF, 16'h0000, 1'b1, 16'h0000);
        run_op("rnd_neg_half", 16'hF000, 16'h0000, 1'b1, 16'h0000);
        run_op("rnd_neg_below", 16'hEFFF, 16'h0000, 1'b1, 16'hFFFF);

        // Saturation (or wrap): 3*3 = 9, 3*-3 = -9, 1.0*max + max.
        load_w(16'h6000);
        run_op("ovf_pos", 16'h6000, 16'h0000, 1'b1, EXP_POS_OVF);
        run_op("ovf_neg", 16'hA000, 16'h0000, 1'b1, EXP_NEG_OVF);
        load_w(16'h2000);
        run_op("ovf_d", 16'h7FFF, 16'h7FFF, 1'b1, EXP_D_OVF);

        // Weight-load race: the coincident op uses the old weight, and the next op uses the new one.
        load_w(16'h2000);
        I_W_LOAD = 1'b1;
        I_W      = 16'h4000;
        issue(16'h2000, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(16'h2000, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        check("race_old_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("race_old", {16'd0, O_OUT}, 32'h2000);
        step();
        check("race_new_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("race_new", {16'd0, O_OUT}, 32'h4000);
        step();
        check("race_done", {31'd0, O_OUT_VLD}, 32'd0);

        // Mode 1: 4 x 0.5 = 2.0, then back-to-back 2 x 0.5 = 1.0. I_D must be ignored.
        load_w(16'h1000);
        issue(16'h2000, 16'h1000, 1'b1, 1'b1, 1'b0);
        issue(16'h2000, 16'h1000, 1'b1, 1'b1, 1'b0);
        issue(16'h2000, 16'h1000, 1'b1, 1'b1, 1'b0);
        check("acc_no_out_1", {31'd0, O_OUT_VLD}, 32'd0);
        issue(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("acc_no_out_2", {31'd0, O_OUT_VLD}, 32'd0);
        issue(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("acc_no_out_3", {31'd0, O_OUT_VLD}, 32'd0);
        issue(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("acc4_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("acc4", {16'd0, O_OUT}, 32'h4000);
        step();
        check("acc_gap_vld", {31'd0, O_OUT_VLD}, 32'd0);
        check("acc_gap_busy", {31'd0, O_BUSY}, 32'd1);
        step();
        check("acc2_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("acc2", {16'd0, O_OUT}, 32'h2000);
        step();
        check("acc_end_vld", {31'd0, O_OUT_VLD}, 32'd0);
        check("acc_end_busy", {31'd0, O_BUSY}, 32'd0);

        // The accumulator alone keeps O_BUSY high across an idle gap.
        issue(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("acc_hold_busy", {31'd0, O_BUSY}, 32'd1);
        check("acc_hold_vld", {31'd0, O_OUT_VLD}, 32'd0);
        issue(16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check("acc_split_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("acc_split", {16'd0, O_OUT}, 32'h3000);
        step();

        // A single-op accumulation dumps round(X*W) directly.
        issue(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check("acc1_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("acc1", {16'd0, O_OUT}, 32'h1000);
        step();

        // The accumulator keeps 9.0 + 9.0 with guard bits, and saturates or truncates only on dump.
        load_w(16'h6000);
        issue(16'h6000, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(16'h6000, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check("acc_ovf_vld", {31'd0, O_OUT_VLD}, 32'd1);
        check("acc_ovf", {16'd0, O_OUT}, {16'd0, EXP_ACC_OVF});
        step();
        check("final_busy", {31'd0, O_BUSY}, 32'd0);
        I_MODE = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_mac_param.md
Name: pe_mac_param

Overview:
- Parametrised next-generation processing element for the MHA systolic matrix engine.
- Signed fixed-point multiply-accumulate per element: O_OUT = sat(round(X*W) + D).
- X is forwarded to the right neighbour; the result goes down to the next row.
- Adds a preloaded stationary weight, a fixed-latency stall-free multiplier pipeline, round-to-nearest, saturation, and an output-stationary accumulate mode.

Parameters:
- DW, 16: data width; signed, 1 sign bit, DW-FW-1 integer bits, FW fraction bits.
- FW, 13: fraction bits; default format is 1 sign, 2 integer, 13 fraction, so 1.0 = 0x2000.
- MUL_STAGES, 2: register stages in the multiplier; minimum 1.
- GUARD, 4: extra integer bits in the mode-1 accumulator; ACC_W = DW+GUARD.

Ports:
- I_CLK  in  1  clock.
- I_RST_N  in  1  reset; asynchronous, active-low; clock I_CLK.
- I_MODE  in  1  0 = pass-down MAC, 1 = local accumulate.
- I_W_LOAD  in  1  load the stationary weight register from I_W.
- I_W  in  DW  weight value.
- I_X_VLD  in  1  X valid; one operation issued per cycle.
- I_X  in  DW  operand from the left.
- I_D_VLD  in  1  partial sum valid; must be coincident with I_X_VLD.
- I_D  in  DW  partial sum from above.
- I_LAST  in  1  mode 1 only: marks the final X of an accumulation.
- O_X_VLD  out  1  forwarded X valid.
- O_X  out  DW  forwarded X.
- O_OUT_VLD  out  1  result valid.
- O_OUT  out  DW  result.
- O_BUSY  out  1  one or more operations in flight, or accumulator non-empty.

Behaviour:
- Reset: all outputs, the weight register, pipeline, accumulator and FSM clear to 0/IDLE. Reset asserted mid-operation discards in-flight data; no O_OUT_VLD for it.
- Weight register:
  - Updated on I_W_LOAD.
  - An op issued in the same cycle as I_W_LOAD uses the OLD weight.
  - Each op samples W at issue, so in-flight ops are unaffected by later loads.
- X forwarding: O_X/O_X_VLD are I_X/I_X_VLD registered one cycle. O_X = 0 when not valid.
- Issue: an op is issued when I_X_VLD=1. If I_D_VLD=0 at issue, D is taken as 0 (top-row case).
- Latency: LAT = MUL_STAGES+1 cycles from issue to O_OUT_VLD; one result per cycle sustained, no backpressure. D is delayed internally to align with the product.
- Arithmetic:
  - P = X*W, signed, 2*DW bits.
  - R = (P + 2^(FW-1)) >>> FW, arithmetic shift.
  - Mode 0: S = R + sext(D).
  - Output saturates to [-2^(DW-1), 2^(DW-1)-1].
- O_OUT = 0 and O_OUT_VLD = 0 in any cycle with no valid result. O_OUT_VLD is a one-cycle pulse per result.
- Mode 1 FSM (IDLE, ACC, DUMP):
  - IDLE -> ACC on the first valid product; the ACC_W accumulator is loaded with R. ACC adds R per valid product.
  - A product tagged I_LAST -> DUMP: O_OUT = sat(acc + R), O_OUT_VLD = 1 for one cycle, accumulator cleared, return to IDLE.
  - If a new product arrives in the DUMP cycle, it seeds the fresh accumulator (back-to-back accumulations, no bubble).
  - I_LAST on a single-op accumulation outputs sat(R) directly.
  - I_D is ignored in mode 1.
- I_MODE is sampled per op at issue; it must change only while O_BUSY=0. A change while busy is undefined (assertion in the bench).

Optional Feature:
- Macro PE_SAT_EN.
- Defined: saturation as specified.
- Undefined: results wrap, taking the low DW bits. The accumulator still holds ACC_W bits and truncates on DUMP.

Decomposition:
- Package mha_pe_pkg:
  - Constants DEFAULT_DW=16, DEFAULT_FW=13.
  - typedef pe_mode_e {PE_MODE_PASS=0, PE_MODE_ACC=1}.
  - FSM state enum.
  - Functions sat_to_dw() and round_shift().
- Sub-module pe_mul_pipe: signed DW x DW multiplier with MUL_STAGES stages and a valid/tag shift register carrying D, mode and last. The top holds the weight register, X forward, adder/saturation and mode-1 FSM.

Test Plan:
- Reset mid-stream: load W=0x2000; issue X=0x2000, D=0x0000; assert reset 1 cycle later -> no O_OUT_VLD after release; all outputs 0.
- Pass mode: W=0x2000; X=0x2000, D=0 -> O_OUT=0x2000 exactly 3 cycles after issue; O_X=0x2000, O_X_VLD one cycle after issue.
- Negative values: W=0x4000 (2.0); X=0xE000 (-1.0), D=0x1000 (0.5) -> O_OUT=0xD000 (-1.5).
- Saturation: W=0x6000; X=0x6000 (3*3=9.0) -> O_OUT=0x7FFF with PE_SAT_EN; 0x2000 without. W=0x6000, X=0xA000 -> 0x8000 with PE_SAT_EN.
- Weight load race: issue X=0x2000 with I_W_LOAD=1, W=0x4000 while the old W=0x2000 -> O_OUT=0x2000; the next op gives 0x4000.
- Mode 1 accumulate: W=0x1000 (0.5); 4 consecutive X=0x2000, I_LAST on the 4th, immediately followed by a 2-op accumulation -> O_OUT=0x4000 pulse LAT after the 4th op, then 0x2000 two cycles later; O_BUSY=0 afterwards.
